// File: rtl/proc_mc.sv
// proc_mc: parametrised multi-cycle processor core (mv/mvi/add/sub/mvnz/ld/st).
// Each instruction is fetched in T0 and finishes in T1, T2 or T3. Done marks its
// final step. A single internal bus carries one source per step.
// Optional build macro: PROC_LOGIC_EN -- when defined, opcodes 4/5/6 perform
// and/or/xor. When undefined they decode as illegal, and the ALU is add/sub only.

// One general register with synchronous reset and write enable.
module proc_mc_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  // Hold the value, load from the bus when addressed, clear on reset
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module proc_mc #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic              Done,
  output logic [DATA_W-1:0] BusWires,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W
);
  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MVNZ = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;
  localparam logic [3:0] OP_ST   = 4'd9;
`ifdef PROC_LOGIC_EN
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
`endif

  typedef enum logic [1:0] {T0, T1, T2, T3} step_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_DIN, SRC_REG, SRC_G} src_e;

  // Only the opcode and register fields are kept; the low bits of the
  // instruction word carry no meaning.
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] x;
    logic [2:0] y;
  } instr_t;

  step_e  state, state_nxt;
  instr_t ir;
  src_e   src;
  logic [2:0] src_reg;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0] a_q, g_q, alu_res;
  logic z_q;
  logic fetch, rf_we, a_ld, g_ld, mem_ld, w_set, alu_op;

`ifdef PROC_LOGIC_EN
  assign alu_op = (ir.op >= OP_ADD) && (ir.op <= OP_XOR);
`else
  assign alu_op = (ir.op == OP_ADD) || (ir.op == OP_SUB);
`endif

  // Register file: every write to Rx comes from the bus
  for (genvar i = 0; i < NREG; i++) begin : g_rf
    proc_mc_reg #(.DATA_W(DATA_W)) u_reg (
      .clk (Clock),
      .rst (Reset),
      .we  (rf_we && (ir.x == 3'(i))),
      .d   (BusWires),
      .q   (regs[i])
    );
  end

  // Bus multiplexer: exactly one source per step, zero when idle
  always_comb begin
    BusWires = '0;
    case (src)
      SRC_DIN: BusWires = DIN;
      SRC_REG: BusWires = regs[src_reg];
      SRC_G:   BusWires = g_q;
      default: BusWires = '0;
    endcase
  end

  // ALU: A op bus, with Ry on the bus during T2
  always_comb begin
    alu_res = '0;
    case (ir.op)
      OP_ADD:  alu_res = a_q + BusWires;
      OP_SUB:  alu_res = a_q - BusWires;
`ifdef PROC_LOGIC_EN
      OP_AND:  alu_res = a_q & BusWires;
      OP_OR:   alu_res = a_q | BusWires;
      OP_XOR:  alu_res = a_q ^ BusWires;
`endif
      default: alu_res = '0;
    endcase
  end

  // Step sequencer: next step, bus source and load strobes for the current step
  always_comb begin
    state_nxt = state;
    Done      = 1'b0;
    fetch     = 1'b0;
    src       = SRC_NONE;
    src_reg   = ir.y;
    rf_we     = 1'b0;
    a_ld      = 1'b0;
    g_ld      = 1'b0;
    mem_ld    = 1'b0;
    w_set     = 1'b0;
    case (state)
      T0: begin
        if (Run) begin
          fetch     = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        if (alu_op) begin
          src       = SRC_REG;
          src_reg   = ir.x;
          a_ld      = 1'b1;
          state_nxt = T2;
        end else begin
          case (ir.op)
            OP_MV:   begin src = SRC_REG; rf_we = 1'b1; Done = 1'b1; end
            OP_MVI:  begin src = SRC_DIN; rf_we = 1'b1; Done = 1'b1; end
            OP_MVNZ: begin src = SRC_REG; rf_we = ~z_q; Done = 1'b1; end
            OP_LD:   begin src = SRC_REG; mem_ld = 1'b1; state_nxt = T2; end
            OP_ST: begin
              src       = SRC_REG;
              mem_ld    = 1'b1;
              w_set     = 1'b1;
              state_nxt = T2;
            end
            default: Done = 1'b1;   // illegal opcode: finish with no side effects
          endcase
        end
      end
      T2: begin
        if (alu_op) begin
          src       = SRC_REG;
          g_ld      = 1'b1;
          state_nxt = T3;
        end else if (ir.op == OP_LD) begin
          state_nxt = T3;           // memory read latency
        end else begin
          Done = 1'b1;              // st completes while W is high
        end
      end
      T3: begin
        src   = alu_op ? SRC_G : SRC_DIN;
        rf_we = 1'b1;
        Done  = 1'b1;
      end
      default: Done = 1'b1;
    endcase
    if (Done) state_nxt = T0;
  end

  // Step register and instruction capture
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (fetch) ir <= instr_t'(DIN[DATA_W-1 -: 10]);
    end
  end

  // Datapath registers and memory port; W is high only for the cycle after st T1
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q  <= '0;
      g_q  <= '0;
      z_q  <= 1'b0;
      ADDR <= '0;
      DOUT <= '0;
      W    <= 1'b0;
    end else begin
      if (a_ld) a_q <= BusWires;
      if (g_ld) begin
        g_q <= alu_res;
        z_q <= (alu_res == '0);
      end
      if (mem_ld) ADDR <= BusWires;
      if (w_set)  DOUT <= regs[ir.x];
      W <= w_set;
    end
  end
endmodule

// File: tb/tb_proc_mc.sv
// Randomised self-checking bench for proc_mc with an instruction-level reference model.
module tb_proc_mc;
  localparam int DW = 16;

  logic          Clock = 1'b0;
  logic          Reset, Run, Done, W;
  logic [DW-1:0] DIN, BusWires, ADDR, DOUT;

  int errors = 0;
  int checks = 0;

  // Architectural model state
  logic [DW-1:0] m_r [8];
  logic          m_z;
  logic [DW-1:0] m_addr, m_dout;
  bit            logic_en;

  proc_mc #(.DATA_W(DW), .NREG(8)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Run      (Run),
    .DIN      (DIN),
    .Done     (Done),
    .BusWires (BusWires),
    .ADDR     (ADDR),
    .DOUT     (DOUT),
    .W        (W)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_alu(input logic [3:0] op);
    return (op == 4'd2) || (op == 4'd3) || (logic_en && op >= 4'd4 && op <= 4'd6);
  endfunction

  function automatic logic [DW-1:0] alu_f(input logic [3:0] op, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    case (op)
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_z = 1'b0; m_addr = '0; m_dout = '0;
  endtask

  task automatic sample(input string ph, input logic exp_done, input logic [DW-1:0] exp_bus,
                        input logic exp_w);
    chk({ph, "_done"}, DW'(Done), DW'(exp_done));
    chk({ph, "_bus"},  BusWires, exp_bus);
    chk({ph, "_w"},    DW'(W), DW'(exp_w));
    chk({ph, "_addr"}, ADDR, m_addr);
    chk({ph, "_dout"}, DOUT, m_dout);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      Reset = 1'b0; Run = 1'b0; DIN = DW'($urandom);
      #1 sample("idle", 1'b0, '0, 1'b0);
    end
  endtask

  // Execute one instruction; data is presented in the step that consumes DIN.
  // abort_at != 0 asserts Reset during that step.
  task automatic exec(input logic [DW-1:0] ins, input logic [DW-1:0] data, input int abort_at);
    logic [3:0]    op;
    int            x, y, n, data_step;
    logic [DW-1:0] rx, ry, res;
    logic [DW-1:0] bus_e [4];
    op = ins[DW-1 -: 4];
    x  = int'(ins[DW-5 -: 3]);
    y  = int'(ins[DW-8 -: 3]);
    rx = m_r[x]; ry = m_r[y];
    res = '0; data_step = 0;
    bus_e = '{default: '0};
    if (op == 4'd0)       begin n = 1; bus_e[1] = ry; end
    else if (op == 4'd1)  begin n = 1; bus_e[1] = data; data_step = 1; end
    else if (is_alu(op))  begin
      n = 3; res = alu_f(op, rx, ry);
      bus_e[1] = rx; bus_e[2] = ry; bus_e[3] = res;
    end
    else if (op == 4'd7)  begin n = 1; bus_e[1] = ry; end
    else if (op == 4'd8)  begin n = 3; bus_e[1] = ry; bus_e[3] = data; data_step = 3; end
    else if (op == 4'd9)  begin n = 2; bus_e[1] = ry; end
    else                  n = 1;

    @(negedge Clock);
    Reset = 1'b0; Run = 1'b1; DIN = ins;
    #1 sample("t0", 1'b0, '0, 1'b0);
    for (int s = 1; s <= n; s++) begin
      @(negedge Clock);
      if (s == 2 && (op == 4'd8 || op == 4'd9)) begin
        m_addr = ry;
        if (op == 4'd9) m_dout = rx;
      end
      Run   = 1'($urandom_range(0, 1));
      DIN   = (s == data_step) ? data : DW'($urandom);
      Reset = (s == abort_at);
      #1 sample($sformatf("op%0d_s%0d", op, s), s == n, bus_e[s], (op == 4'd9) && (s == 2));
      if (s == abort_at) begin
        clear_model();
        @(negedge Clock);
        Reset = 1'b0; Run = 1'b0;
        #1 sample("after_rst", 1'b0, '0, 1'b0);
        return;
      end
    end
    case (op)
      4'd0: m_r[x] = ry;
      4'd1: m_r[x] = data;
      4'd7: if (!m_z) m_r[x] = ry;
      4'd8: m_r[x] = data;
      default: if (is_alu(op)) begin m_r[x] = res; m_z = (res == '0); end
    endcase
  endtask

  // mv Ri,Ri puts Ri on the bus without changing it
  task automatic readback();
    logic [2:0] r;
    for (int i = 0; i < 8; i++) begin
      r = i[2:0];
      exec({4'h0, r, r, 6'h00}, '0, 0);
    end
  endtask

  initial begin
`ifdef PROC_LOGIC_EN
    logic_en = 1'b1;
`else
    logic_en = 1'b0;
`endif
    clear_model();
    Reset = 1'b1; Run = 1'b1; DIN = 16'h1000;
    @(negedge Clock);
    @(negedge Clock);
    #1 sample("reset", 1'b0, '0, 1'b0);

    exec(16'h1000, 16'h0005, 0);   // mvi R0,5
    exec(16'h1200, 16'h0003, 0);   // mvi R1,3
    exec(16'h2040, '0, 0);         // add R0,R1 -> 8
    exec(16'h3000, '0, 0);         // sub R0,R0 -> 0, Z=1
    exec(16'h7440, '0, 0);         // mvnz R2,R1 suppressed
    exec(16'h2040, '0, 0);         // add R0,R1 -> 3, Z=0
    exec(16'h7440, '0, 0);         // mvnz R2,R1 -> R2=3
    exec(16'h1600, 16'h00A0, 0);   // mvi R3,0xA0
    exec(16'h1800, 16'h1234, 0);   // mvi R4,0x1234
    exec(16'h98C0, '0, 0);         // st R4,[R3]
    exec(16'h8AC0, 16'hBEEF, 0);   // ld R5,[R3]
    readback();
    exec(16'hF000, '0, 0);         // illegal
    exec(16'h4040, '0, 0);         // and R0,R1 or illegal
    readback();
    exec(16'h2040, '0, 2);         // add aborted by reset in T2
    readback();

    // Reset and Run together: no fetch
    @(negedge Clock);
    Reset = 1'b1; Run = 1'b1; DIN = 16'h1000;
    #1 sample("rst_run", 1'b0, '0, 1'b0);
    clear_model();
    @(negedge Clock);
    Reset = 1'b0; Run = 1'b0;
    #1 sample("no_fetch", 1'b0, '0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
      exec(DW'($urandom), DW'($urandom),
           ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 3)) : 0);
      if (k % 50 == 49) readback();
    end
    readback();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
